// File: rtl/bit_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bit_serializer: parallel-to-serial shifter with a one-word hold stage  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned              c_cnt_w   = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0]       c_cnt_max = c_cnt_w'(WIDTH - 1);
  localparam logic [0:0]               c_idle    = 1'b0;
  localparam logic [0:0]               c_shift   = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;
  logic [WIDTH-1:0]   r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_hold_full;
  logic               w_xfer;
  logic               w_last;
  logic               w_out_bit;
  logic [WIDTH-1:0]   w_shifted;

  // ready depends only on the hold flag, so accepting never loops back through valid
  assign w_xfer = valid_i && !r_hold_full;
  assign w_last = (r_cnt == '0);

  if (MSB_FIRST) begin : g_msb_first
    assign w_out_bit = r_shift[WIDTH-1];
    assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_out_bit = r_shift[0];
    assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = c_idle;
    end else if (r_state == c_idle) begin
      if (w_xfer) w_state_next = c_shift;
    end else if (w_last && !r_hold_full && !w_xfer) begin
      w_state_next = c_idle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (flush_i) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
    end else if (r_state == c_idle) begin
      if (w_xfer) begin
        r_shift <= data_i;
        r_cnt   <= c_cnt_max;
      end
    end else if (!w_last) begin
      r_shift <= w_shifted;
      r_cnt   <= r_cnt - 1'b1;
      if (w_xfer) begin
        r_hold      <= data_i;
        r_hold_full <= 1'b1;
      end
    end else if (r_hold_full) begin
      // last bit leaving: the held word follows with no gap cycle
      r_shift     <= r_hold;
      r_hold_full <= 1'b0;
      r_cnt       <= c_cnt_max;
    end else if (w_xfer) begin
      r_shift <= data_i;
      r_cnt   <= c_cnt_max;
    end
  end

  always_comb begin
    ready_o     = !r_hold_full;
    bit_valid_o = (r_state == c_shift);
    bit_o       = (r_state == c_shift) && w_out_bit;
    last_o      = (r_state == c_shift) && w_last;
    busy_o      = (r_state == c_shift) || r_hold_full;
  end

endmodule
`default_nettype wire
